spi_txn_scheduler: RTL and testbench
====================================

# spi_txn_scheduler

Arbitrates and sequences SPI transactions from several requesters onto the single SPI master. Each requester names a start address and burst length in the shared data stash. The scheduler grants one requester at a time in round-robin order and holds the master's active-low enable for the whole burst. It steps the stash pointer once per completed byte, then releases the bus and signals completion.

## Interface
- N_REQ, 4, number of requesters (2..8)
- PTR_W, 8, stash address width
- LEN_W, 4, burst length field width; encoded as bytes minus one (max burst 2^LEN_W bytes)
- TIMEOUT_CYC, 1024, watchdog limit in CTRL_CLK cycles (used only with the macro)

- CTRL_CLK  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  N_REQ  level request per requester
- REQ_ADDR  in  N_REQ*PTR_W  start stash address; requester i at [i*PTR_W +: PTR_W]
- REQ_LEN  in  N_REQ*LEN_W  burst length minus one; requester i at [i*LEN_W +: LEN_W]
- GNT  out  N_REQ  one-hot grant, held for the entire transaction
- DONE  out  N_REQ  one-cycle completion pulse to the granted requester
- ERR  out  1  one-cycle abort pulse (watchdog)
- BUSY  out  1  high in any state other than IDLE
- M_EN_N  out  1  active-low transaction enable to the SPI master
- M_BYTE_DONE  in  1  one-cycle pulse from the master per completed byte
- M_IDLE  in  1  master idle with CS high
- STASH_PTR  out  PTR_W  current stash address

## Operation
- States: IDLE, XFER, RELEASE.
- IDLE: M_EN_N=1, GNT=0. If any REQ bit is set, select the winner by round-robin, starting the search at (last_winner+1) mod N_REQ. After reset the search starts at requester 0.
- On grant, latch REQ_ADDR and REQ_LEN of the winner. Set STASH_PTR to the latched address and remaining count to the latched length. Assert the one-hot GNT, drive M_EN_N=0, and enter XFER.
- XFER, on M_BYTE_DONE:
  - If count==0, go to RELEASE.
  - Otherwise, STASH_PTR <= STASH_PTR+1 (mod 2^PTR_W; 0xFF wraps to 0x00 for PTR_W=8) and count <= count-1.
- RELEASE: M_EN_N=1 and GNT still held. When M_IDLE=1, pulse DONE[winner], clear GNT, update last_winner, and go to IDLE.
- REQ deassertion during XFER/RELEASE is ignored; the burst always completes. REQ_ADDR/REQ_LEN changes after grant are ignored.
- A requester holding REQ high after DONE re-enters arbitration; round-robin ensures other pending requesters win first.
- STASH_PTR holds its last value in IDLE and RELEASE.

## Timing
- Reset values: GNT=0, DONE=0, ERR=0, BUSY=0, M_EN_N=1, STASH_PTR=0, last_winner=N_REQ-1, state IDLE.
- Reset mid-transaction returns immediately to these values. M_EN_N rising aborts the master, and no DONE is issued.
- REQ high in IDLE at edge t: GNT, M_EN_N=0, STASH_PTR=addr and BUSY are valid after edge t (one-cycle latency).
- M_BYTE_DONE sampled at edge t: STASH_PTR advances after edge t, so it is valid for the next byte load.
- Last M_BYTE_DONE at edge t: M_EN_N=1 after edge t.
- DONE pulses in the cycle after the first edge at which M_IDLE=1 is sampled in RELEASE. The next grant is earliest one cycle after DONE.
- All outputs are registered.

## Configuration
- Macro SPI_TXN_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on each M_BYTE_DONE, and increments every cycle in XFER and RELEASE.
  - On reaching TIMEOUT_CYC: pulse ERR, drive M_EN_N=1, clear GNT without DONE, and go to IDLE.
  - last_winner still updates, so the next arbitration search starts after the aborted requester.
- Not defined: no counter; ERR tied to 0; a stalled master stalls the scheduler indefinitely.

## Test plan
- Single request: REQ=4'b0001, addr 0x10, len 2. Expect GNT=0001, and STASH_PTR 0x10→0x11→0x12 on three M_BYTE_DONE pulses. After M_IDLE, expect DONE=0001 and M_EN_N high before DONE.
- Round-robin: REQ=4'b1111 held, len 0 each. Expect grants 0001, 0010, 0100, 1000, 0001 in order, with exactly one DONE per grant.
- Wrap-around: addr 0xFE, len 3. Expect STASH_PTR sequence 0xFE, 0xFF, 0x00, 0x01, then DONE.
- Withdrawal and late data: REQ[2] dropped and REQ_ADDR[2] changed after grant. Expect the burst to finish at the original addresses and DONE[2] to pulse.
- Reset mid-XFER: assert RST after one byte. Expect immediate GNT=0, M_EN_N=1, STASH_PTR=0, no DONE, and the next grant to requester 0.
- With SPI_TXN_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: grant, then no M_BYTE_DONE. Expect a one-cycle ERR pulse with GNT cleared and no DONE; the next pending requester is then granted.

Source files
------------

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin arbiter that runs one SPI burst at a time for the granted requester
// Ports: CTRL_CLK/RST (async active-high); REQ/REQ_ADDR/REQ_LEN requester side;
//        GNT/DONE/ERR/BUSY status; M_EN_N/M_BYTE_DONE/M_IDLE master handshake; STASH_PTR stash address.
// Optional: `define SPI_TXN_SCHED_TIMEOUT_EN adds a watchdog that aborts a burst after TIMEOUT_CYC idle cycles.
module spi_txn_scheduler #(
   parameter int N_REQ       = 4,
   parameter int PTR_W       = 8,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   CTRL_CLK,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*PTR_W-1:0] REQ_ADDR,
   input  logic [N_REQ*LEN_W-1:0] REQ_LEN,
   output logic [N_REQ-1:0]       GNT,
   output logic [N_REQ-1:0]       DONE,
   output logic                   ERR,
   output logic                   BUSY,
   output logic                   M_EN_N,
   input  logic                   M_BYTE_DONE,
   input  logic                   M_IDLE,
   output logic [PTR_W-1:0]       STASH_PTR
);
   localparam int IDX_W = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
   state_t state;
   logic [IDX_W-1:0] last_winner, winner, win;
   logic [LEN_W-1:0] cnt;
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wd;
`endif
   // scan farthest-to-nearest from last_winner so the nearest pending requester wins
   always_comb begin
      win = last_winner;
      for (int k = N_REQ; k >= 1; k--)
         if (REQ[(int'(last_winner) + k) % N_REQ]) win = IDX_W'((int'(last_winner) + k) % N_REQ);
   end
   always_ff @(posedge CTRL_CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         GNT         <= '0;
         DONE        <= '0;
         ERR         <= 1'b0;
         BUSY        <= 1'b0;
         M_EN_N      <= 1'b1;
         STASH_PTR   <= '0;
         last_winner <= IDX_W'(N_REQ - 1);
         winner      <= '0;
         cnt         <= '0;
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
         wd          <= '0;
`endif
      end else begin
         DONE <= '0;
         ERR  <= 1'b0;
         case (state)
            IDLE: if (|REQ) begin
               winner    <= win;
               STASH_PTR <= REQ_ADDR[win*PTR_W +: PTR_W];
               cnt       <= REQ_LEN[win*LEN_W +: LEN_W];
               GNT       <= N_REQ'(1) << win;
               M_EN_N    <= 1'b0;
               BUSY      <= 1'b1;
               state     <= XFER;
            end
            XFER: if (M_BYTE_DONE) begin
               if (cnt == '0) begin
                  M_EN_N <= 1'b1;
                  state  <= RELEASE;
               end else begin
                  STASH_PTR <= STASH_PTR + 1'b1;
                  cnt       <= cnt - 1'b1;
               end
            end
            RELEASE: if (M_IDLE) begin
               DONE        <= GNT;
               GNT         <= '0;
               BUSY        <= 1'b0;
               last_winner <= winner;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
         // watchdog abort overrides any normal progress in the same cycle
         if (state == IDLE) wd <= '0;
         else begin
            wd <= M_BYTE_DONE ? '0 : wd + 1'b1;
            if (!M_BYTE_DONE && wd == TO_W'(TIMEOUT_CYC - 1)) begin
               ERR         <= 1'b1;
               DONE        <= '0;
               GNT         <= '0;
               M_EN_N      <= 1'b1;
               BUSY        <= 1'b0;
               last_winner <= winner;
               state       <= IDLE;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb_spi_txn_scheduler: scoreboard bench for spi_txn_scheduler
module tb_spi_txn_scheduler;
   logic        CTRL_CLK, RST, M_BYTE_DONE, M_IDLE, ERR, BUSY, M_EN_N;
   logic [3:0]  REQ, GNT, DONE;
   logic [31:0] REQ_ADDR;
   logic [15:0] REQ_LEN;
   logic [7:0]  STASH_PTR;
   logic [7:0]  addr_m [4];
   logic [3:0]  len_m [4];
   logic [7:0]  ptr_q [$];
   int tests_run, fails, done_cnt;

   spi_txn_scheduler #(.N_REQ(4), .PTR_W(8), .LEN_W(4), .TIMEOUT_CYC(16)) dut (
      .CTRL_CLK(CTRL_CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
      .GNT(GNT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .M_EN_N(M_EN_N),
      .M_BYTE_DONE(M_BYTE_DONE), .M_IDLE(M_IDLE), .STASH_PTR(STASH_PTR)
   );

   initial CTRL_CLK = 1'b0;
   always #5 CTRL_CLK = ~CTRL_CLK;
   always @(negedge CTRL_CLK) done_cnt += $countones(DONE);

   task automatic tick();
      @(posedge CTRL_CLK);
      #1;
   endtask

   task automatic set_req(input int r, input logic [7:0] a, input logic [3:0] l);
      addr_m[r] = a;
      len_m[r]  = l;
      REQ_ADDR[r*8 +: 8] = a;
      REQ_LEN[r*4 +: 4]  = l;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      REQ = '0;
      ptr_q.delete();
      tick();
      RST = 1'b0;
   endtask

   task automatic xfer(input int r, input bit drop, input bit scramble);
      logic [3:0] eg;
      logic [7:0] e, last;
      int n;
      eg = 4'b0001 << r;
      last = '0;
      for (int b = 0; b <= int'(len_m[r]); b++) ptr_q.push_back(8'(int'(addr_m[r]) + b));
      n = 0;
      while (GNT === 4'b0 && n < 8) begin tick(); n++; end
      tests_run++;
      if (GNT !== eg) begin fails++; $display("FAIL grant got %b exp %b", GNT, eg); end
      tests_run++;
      if ({M_EN_N, BUSY} !== 2'b01) begin fails++; $display("FAIL en_busy got %b exp 01", {M_EN_N, BUSY}); end
      if (drop) REQ = '0;
      if (scramble) begin
         REQ_ADDR[r*8 +: 8] = ~addr_m[r];
         REQ_LEN[r*4 +: 4]  = 4'd0;
      end
      for (int b = 0; b <= int'(len_m[r]); b++) begin
         e = ptr_q.pop_front();
         last = e;
         tests_run++;
         if (STASH_PTR !== e) begin fails++; $display("FAIL ptr byte %0d got %h exp %h", b, STASH_PTR, e); end
         M_BYTE_DONE = 1'b1;
         tick();
         M_BYTE_DONE = 1'b0;
         if (b % 2 == 1) tick();
      end
      tests_run++;
      if ({M_EN_N, GNT, STASH_PTR} !== {1'b1, eg, last}) begin
         fails++;
         $display("FAIL release got en=%b gnt=%b ptr=%h exp en=1 gnt=%b ptr=%h", M_EN_N, GNT, STASH_PTR, eg, last);
      end
      tests_run++;
      if (DONE !== 4'b0) begin fails++; $display("FAIL early_done got %b exp 0000", DONE); end
      M_IDLE = 1'b1;
      n = 0;
      while (DONE === 4'b0 && n < 8) begin tick(); n++; end
      M_IDLE = 1'b0;
      tests_run++;
      if (DONE !== eg) begin fails++; $display("FAIL done got %b exp %b", DONE, eg); end
      tests_run++;
      if ({GNT, BUSY} !== 5'b0) begin fails++; $display("FAIL post_done gnt/busy got %b exp 00000", {GNT, BUSY}); end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #1;
      tests_run++;
      if ({GNT, DONE, ERR, BUSY, M_EN_N, STASH_PTR} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
         fails++;
         $display("FAIL reset got gnt=%b done=%b err=%b busy=%b en=%b ptr=%h exp 0000 0000 0 0 1 00",
                  GNT, DONE, ERR, BUSY, M_EN_N, STASH_PTR);
      end
      tick();
      RST = 1'b0;
      tick();
      tests_run++;
      if ({GNT, BUSY, M_EN_N} !== 6'b000001) begin fails++; $display("FAIL idle got %b exp 000001", {GNT, BUSY, M_EN_N}); end
   endtask

   task automatic test_single();
      set_req(0, 8'h10, 4'd2);
      REQ = 4'b0001;
      xfer(0, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      set_req(1, 8'hFE, 4'd3);
      REQ = 4'b0010;
      xfer(1, 1'b1, 1'b0);
   endtask

   task automatic test_withdraw();
      set_req(2, 8'h40, 4'd2);
      REQ = 4'b0100;
      xfer(2, 1'b1, 1'b1);
      set_req(2, 8'h40, 4'd2);
   endtask

   task automatic test_round_robin();
      int d0;
      do_reset();
      for (int r = 0; r < 4; r++) set_req(r, 8'(8'h80 + 16 * r), 4'd0);
      d0 = done_cnt;
      REQ = 4'b1111;
      for (int r = 0; r < 4; r++) xfer(r, 1'b0, 1'b0);
      xfer(0, 1'b1, 1'b0);
      tick();
      tests_run++;
      if (done_cnt - d0 !== 5) begin fails++; $display("FAIL rr_done_count got %0d exp 5", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int n, d0;
      set_req(3, 8'h30, 4'd3);
      REQ = 4'b1000;
      n = 0;
      while (GNT === 4'b0 && n < 8) begin tick(); n++; end
      tests_run++;
      if (GNT !== 4'b1000) begin fails++; $display("FAIL rst_grant got %b exp 1000", GNT); end
      M_BYTE_DONE = 1'b1;
      tick();
      M_BYTE_DONE = 1'b0;
      tests_run++;
      if (STASH_PTR !== 8'h31) begin fails++; $display("FAIL rst_ptr1 got %h exp 31", STASH_PTR); end
      d0 = done_cnt;
      RST = 1'b1;
      #1;
      tests_run++;
      if ({GNT, M_EN_N, BUSY, STASH_PTR} !== {4'b0, 1'b1, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL rst_mid got gnt=%b en=%b busy=%b ptr=%h exp 0000 1 0 00", GNT, M_EN_N, BUSY, STASH_PTR);
      end
      tick();
      RST = 1'b0;
      REQ = 4'b1001;
      xfer(0, 1'b1, 1'b0);
      tick();
      tests_run++;
      if (done_cnt - d0 !== 1) begin fails++; $display("FAIL rst_done_count got %0d exp 1", done_cnt - d0); end
   endtask

`ifdef SPI_TXN_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n, d0;
      do_reset();
      set_req(0, 8'h50, 4'd1);
      set_req(1, 8'h60, 4'd0);
      REQ = 4'b0011;
      n = 0;
      while (GNT === 4'b0 && n < 8) begin tick(); n++; end
      tests_run++;
      if (GNT !== 4'b0001) begin fails++; $display("FAIL to_grant got %b exp 0001", GNT); end
      d0 = done_cnt;
      n = 0;
      while (ERR !== 1'b1 && n < 40) begin tick(); n++; end
      tests_run++;
      if ({ERR, GNT, DONE, M_EN_N} !== {1'b1, 4'b0, 4'b0, 1'b1}) begin
         fails++;
         $display("FAIL to_abort got err=%b gnt=%b done=%b en=%b exp 1 0000 0000 1", ERR, GNT, DONE, M_EN_N);
      end
      tick();
      tests_run++;
      if ({ERR, GNT} !== 5'b00010) begin fails++; $display("FAIL to_next got err=%b gnt=%b exp 0 0010", ERR, GNT); end
      tests_run++;
      if (done_cnt !== d0) begin fails++; $display("FAIL to_no_done got %0d exp %0d", done_cnt, d0); end
      REQ = '0;
      ptr_q.push_back(8'h60);
      tests_run++;
      if (STASH_PTR !== ptr_q.pop_front()) begin fails++; $display("FAIL to_ptr got %h exp 60", STASH_PTR); end
      do_reset();
   endtask
`endif

   initial begin
      tests_run = 0;
      fails = 0;
      done_cnt = 0;
      RST = 1'b1;
      REQ = '0;
      REQ_ADDR = '0;
      REQ_LEN = '0;
      M_BYTE_DONE = 1'b0;
      M_IDLE = 1'b0;
      test_reset();
      test_single();
      test_wrap();
      test_withdraw();
      test_round_robin();
      test_reset_mid();
`ifdef SPI_TXN_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached at %0t", $time);
      $fatal(1, "bench timeout");
   end
endmodule
